// File: rtl/qram_access_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : qram_access_scheduler_if
// Brief    : Request/response and cell-array signal bundle for the QRAM
//            access scheduler. The scheduler uses the slave view; the
//            requesters and the array model use the master view.
// Revision : 1.0 - initial release
// ============================================================================
interface qram_access_scheduler_if #(
  parameter int ADDR_WIDTH = 4
);
  // Requester A
  logic                  ReqValidA;
  logic                  ReqWriteA;
  logic [ADDR_WIDTH-1:0] ReqAddrA;
  logic                  ReqDataA;
  logic                  ReqReadyA;
  // Requester B
  logic                  ReqValidB;
  logic                  ReqWriteB;
  logic [ADDR_WIDTH-1:0] ReqAddrB;
  logic                  ReqDataB;
  logic                  ReqReadyB;
  // Read response
  logic                  RspValid;
  logic                  RspData;
  logic                  RspPort;
  // Cell array
  logic [ADDR_WIDTH-1:0] CellAddress;
  logic                  CellInputData;
  logic                  CellWriteEdge;
  logic                  CellReadEdge;
  logic                  CellOutputData;
  // Status
  logic                  Busy;

  modport slave (
    input  ReqValidA, ReqWriteA, ReqAddrA, ReqDataA,
    input  ReqValidB, ReqWriteB, ReqAddrB, ReqDataB,
    input  CellOutputData,
    output ReqReadyA, ReqReadyB,
    output RspValid, RspData, RspPort,
    output CellAddress, CellInputData, CellWriteEdge, CellReadEdge,
    output Busy
  );

  modport master (
    output ReqValidA, ReqWriteA, ReqAddrA, ReqDataA,
    output ReqValidB, ReqWriteB, ReqAddrB, ReqDataB,
    output CellOutputData,
    input  ReqReadyA, ReqReadyB,
    input  RspValid, RspData, RspPort,
    input  CellAddress, CellInputData, CellWriteEdge, CellReadEdge,
    input  Busy
  );
endinterface
`default_nettype wire

// File: rtl/qram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qram_access_scheduler
// Brief    : Round-robin arbiter and strobe sequencer for the single-bit QRAM
//            cell array, with periodic read/write-back refresh of one cell.
// Revision : 1.0 - initial release
// ============================================================================
module qram_access_scheduler #(
  parameter int ADDR_WIDTH       = 4,
  parameter int STROBE_CYCLES    = 2,
  parameter int REFRESH_INTERVAL = 64
) (
  input wire clk,
  input wire rst,
  qram_access_scheduler_if.slave bus
);

  localparam int c_STB_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int c_REF_W = $clog2(REFRESH_INTERVAL);
  localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(STROBE_CYCLES - 1);
  localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [c_STB_W-1:0]    r_strobeCnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_data;
  logic                  r_write;
  logic                  r_port;
  logic                  r_refresh;     // current access belongs to a refresh
  logic                  r_lastGrant;   // 0 = A, 1 = B
  logic                  r_rdSample;
  logic [c_REF_W-1:0]    r_refreshCnt;
  logic                  r_refreshPending;
  logic [ADDR_WIDTH-1:0] r_refreshAddr;

  logic w_grantA;
  logic w_grantB;
  logic w_readyA;
  logic w_readyB;
  logic w_startRefresh;
  logic w_strobeLast;

  assign w_strobeLast = (r_strobeCnt == c_STB_LAST);

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state, round-robin grant and request-ready decode.
  always_comb begin
    w_nextState    = r_state;
    w_grantA       = bus.ReqValidA && (!bus.ReqValidB || r_lastGrant);
    w_grantB       = bus.ReqValidB && (!bus.ReqValidA || !r_lastGrant);
    w_readyA       = 1'b0;
    w_readyB       = 1'b0;
    w_startRefresh = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_refreshPending) begin
          w_startRefresh = 1'b1;
          w_nextState    = SETUP;
        end else begin
          w_readyA = w_grantA;
          w_readyB = w_grantB;
          if (w_grantA || w_grantB) begin
            w_nextState = SETUP;
          end
        end
      end
      SETUP:   w_nextState = STROBE;
      STROBE:  if (w_strobeLast) w_nextState = RECOVER;
      RECOVER: w_nextState = (r_refresh && !r_write) ? SETUP : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Access latch, strobe counter and read sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_data      <= 1'b0;
      r_write     <= 1'b0;
      r_port      <= 1'b0;
      r_refresh   <= 1'b0;
      r_lastGrant <= 1'b1;
      r_rdSample  <= 1'b0;
      r_strobeCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startRefresh) begin
            r_addr    <= r_refreshAddr;
            r_write   <= 1'b0;
            r_refresh <= 1'b1;
          end else if (w_readyA) begin
            r_addr      <= bus.ReqAddrA;
            r_data      <= bus.ReqDataA;
            r_write     <= bus.ReqWriteA;
            r_port      <= 1'b0;
            r_refresh   <= 1'b0;
            r_lastGrant <= 1'b0;
          end else if (w_readyB) begin
            r_addr      <= bus.ReqAddrB;
            r_data      <= bus.ReqDataB;
            r_write     <= bus.ReqWriteB;
            r_port      <= 1'b1;
            r_refresh   <= 1'b0;
            r_lastGrant <= 1'b1;
          end
        end
        STROBE: begin
          r_strobeCnt <= w_strobeLast ? '0 : r_strobeCnt + 1'b1;
          if (!r_write && w_strobeLast) begin
            r_rdSample <= bus.CellOutputData;
          end
        end
        RECOVER: begin
          // Refresh read pass turns into the write-back of the sampled bit.
          if (r_refresh && !r_write) begin
            r_write <= 1'b1;
            r_data  <= r_rdSample;
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh interval counter, saturating pending flag and refresh address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refreshCnt     <= '0;
      r_refreshPending <= 1'b0;
      r_refreshAddr    <= '0;
    end else begin
      if (r_refreshCnt == c_REF_LAST) begin
        r_refreshCnt <= '0;
      end else begin
        r_refreshCnt <= r_refreshCnt + 1'b1;
      end
      // A wrap on the same cycle a refresh starts keeps the flag set.
      if (r_refreshCnt == c_REF_LAST) begin
        r_refreshPending <= 1'b1;
      end else if (w_startRefresh) begin
        r_refreshPending <= 1'b0;
      end
      if (r_state == RECOVER && r_refresh && r_write) begin
        r_refreshAddr <= r_refreshAddr + 1'b1;
      end
    end
  end

  assign bus.ReqReadyA     = w_readyA;
  assign bus.ReqReadyB     = w_readyB;
  assign bus.CellAddress   = r_addr;
  assign bus.CellInputData = r_data;
  assign bus.CellWriteEdge = (r_state == STROBE) && r_write;
  assign bus.CellReadEdge  = (r_state == STROBE) && !r_write;
  assign bus.RspValid      = (r_state == RECOVER) && !r_write && !r_refresh;
  assign bus.RspData       = r_rdSample;
  assign bus.RspPort       = r_port;
  assign bus.Busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/qram_access_scheduler.md
# qram_access_scheduler

Sequencing and arbitration controller for the single-bit QRAM cell array. Accepts read/write requests from two requesters (A, B), arbitrates round-robin, and drives the array's address, write-edge and read-edge strobes with fixed setup/strobe/recover phasing. Inserts periodic refresh cycles (read then write-back of one cell) so stored QBits are re-driven at a bounded interval, in the manner of SDRAM refresh.

## Interface
- AddrWidth, 4, width of cell address; array holds 2^AddrWidth cells
- StrobeCycles, 2, cycles the WriteEdge/ReadEdge strobe is held high (≥1)
- RefreshInterval, 64, clock cycles between refresh requests (≥ 4*(StrobeCycles+2))

- Clock  input  1  single system clock; all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- ReqValidA / ReqValidB  input  1  request present
- ReqWriteA / ReqWriteB  input  1  1 = write, 0 = read
- ReqAddrA / ReqAddrB  input  AddrWidth  target cell
- ReqDataA / ReqDataB  input  1  write data (ignored on read)
- ReqReadyA / ReqReadyB  output  1  request accepted this cycle when Valid && Ready
- RspValid  output  1  one-cycle pulse: read data valid
- RspData  output  1  read data
- RspPort  output  1  0 = A, 1 = B; owner of RspData
- CellAddress  output  AddrWidth  address to array
- CellInputData  output  1  data to array write path
- CellWriteEdge  output  1  write strobe
- CellReadEdge  output  1  read strobe
- CellOutputData  input  1  data from array read path
- Busy  output  1  FSM not in IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- IDLE: if RefreshPending, start refresh read pass (no ReqReady). Else grant a requester: if one valid, that one; if both, the one not granted last (LastGrant). ReqReadyX combinational = IDLE && !RefreshPending && grantX. On handshake, latch addr/data/write/port, update LastGrant, go SETUP.
- SETUP: 1 cycle; CellAddress, CellInputData driven from latch; both edges low.
- STROBE: StrobeCycles cycles; CellWriteEdge (write) or CellReadEdge (read) high; CellAddress/CellInputData stable. Read: CellOutputData sampled into RspData on last STROBE cycle.
- RECOVER: 1 cycle, edges low. User read: RspValid=1, RspPort=latched port. Then IDLE; refresh read pass instead goes SETUP for write pass.
- Write-back: write pass writes sampled read value to same address; no RspValid for refresh.
- Refresh: counter counts 0..RefreshInterval-1, wraps; on wrap set RefreshPending (saturating; wrap while already pending does not queue a second). Pending cleared on entering refresh read SETUP. RefreshAddr increments after write-pass RECOVER, wraps 2^AddrWidth-1 → 0. Refresh wins over requests only at IDLE; never preempts a transaction in progress.
- Address/data outputs hold last value in IDLE; edges always low outside STROBE.

## Timing
- Reset (async, immediate): FSM IDLE, all outputs 0, RefreshAddr 0, refresh counter 0, RefreshPending 0, LastGrant = B (A wins first tie). Reset mid-transaction drops edges at once; transaction lost, no RspValid.
- Handshake at cycle 0 → SETUP cycle 1 → STROBE cycles 2..1+StrobeCycles → RECOVER cycle 2+StrobeCycles (RspValid here for reads) → IDLE cycle 3+StrobeCycles; next handshake earliest that cycle. Throughput: one access per StrobeCycles+3 cycles.
- Refresh occupies 2*(StrobeCycles+2) cycles plus return to IDLE.
- ReqValid may drop without handshake; no request held internally until handshake.

## Test plan
- Write A addr 5 data 1, then read A addr 5 (StrobeCycles=2) → CellWriteEdge high cycles 2–3, read RspValid at cycle 4 of read, RspData=1, RspPort=0.
- Both ReqValid high continuously after reset → grants A, B, A, B; ReqReady never high for both same cycle.
- RefreshInterval=16, idle bus, cell 0 preloaded 1 → refresh reads then writes 1 to addr 0, next refresh targets addr 1; RspValid stays 0; wraps to 0 after addr 15.
- Refresh pending while A read in STROBE → A completes with RspValid, refresh runs next, ReqReadyA low until refresh done.
- Assert Reset during STROBE of a write → CellWriteEdge falls same cycle, all outputs 0, no RspValid; after release A wins first tie.
- Stall: counter wraps twice while long request stream → only one refresh queued per pending flag, RefreshAddr advances by 1.
